// File: rtl/router_pkg.sv
// Shared router definitions: port numbering, index width and allocator state type.
package router_pkg;

    localparam int NPORT = 5;
    localparam int SELW  = 3;

    localparam int PORT_N = 0;
    localparam int PORT_E = 1;
    localparam int PORT_S = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    typedef logic [SELW-1:0] port_idx_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } alloc_state_t;

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after ptr,
// wrapping around the port ring.
module rr_arbiter
    import router_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  port_idx_t        ptr,
    output logic [NPORT-1:0] grant,
    output port_idx_t        idx
);

    // Walk the ring from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int unsigned i = NPORT; i >= 1; i--) begin
            int unsigned cand;
            cand = (int'(ptr) + i) % NPORT;
            if (req[cand]) begin
                grant       = '0;
                grant[cand] = 1'b1;
                idx         = port_idx_t'(cand);
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Output-port switch allocator for the 5-port mesh router with per-output
// round-robin arbitration and wormhole locking (head flit to tail flit).
// Optional macro SA_FASTGRANT_EN: an idle output grants and transfers in the
// same cycle when its downstream is ready (zero-cycle arbitration latency).
module switch_allocator
    import router_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NPORT-1:0]      in_valid,
    input  logic [NPORT*SELW-1:0] in_dir,
    input  logic [NPORT-1:0]      in_tail,
    input  logic [NPORT-1:0]      out_ready,
    output logic [NPORT-1:0]      pop,
    output logic [NPORT-1:0]      out_valid,
    output logic [NPORT*SELW-1:0] out_sel,
    output logic [NPORT-1:0]      out_lock,
    output logic                  dir_err
);

    alloc_state_t     state   [NPORT];
    port_idx_t        owner   [NPORT];
    port_idx_t        ptr     [NPORT];
    logic [NPORT-1:0] req     [NPORT];
    logic [NPORT-1:0] arb_grant [NPORT];
    port_idx_t        arb_idx [NPORT];
    logic [NPORT-1:0] arb_any;
    port_idx_t        sel_now [NPORT];
    logic [NPORT-1:0] locked_xfer;
    logic [NPORT-1:0] fast_xfer;
    logic             dir_bad;
    logic             dir_err_q;

    // Build the request matrix; U-turns are dropped and illegal directions flagged.
    always_comb begin
        dir_bad = 1'b0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            req[o] = '0;
        end
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (in_valid[p]) begin
                if (in_dir[p*SELW +: SELW] >= port_idx_t'(NPORT)) begin
                    dir_bad = 1'b1;
                end else if (in_dir[p*SELW +: SELW] != port_idx_t'(p)) begin
                    req[in_dir[p*SELW +: SELW]][p] = 1'b1;
                end
            end
        end
    end

    for (genvar o = 0; o < NPORT; o++) begin : g_arb
        rr_arbiter u_arb (
            .req   (req[o]),
            .ptr   (ptr[o]),
            .grant (arb_grant[o]),
            .idx   (arb_idx[o])
        );
        assign arb_any[o] = |arb_grant[o];
    end

    // Transfer qualification, crossbar selects and FIFO pop strobes.
    always_comb begin
        pop       = '0;
        out_valid = '0;
        out_sel   = '0;
        out_lock  = '0;
        for (int unsigned o = 0; o < NPORT; o++) begin
            locked_xfer[o] = (state[o] == LOCKED) && in_valid[owner[o]] &&
                             (in_dir[int'(owner[o])*SELW +: SELW] == port_idx_t'(o)) &&
                             out_ready[o];
`ifdef SA_FASTGRANT_EN
            fast_xfer[o] = rst_n && (state[o] == IDLE) && arb_any[o] && out_ready[o];
`else
            fast_xfer[o] = 1'b0;
`endif
            sel_now[o] = fast_xfer[o] ? arb_idx[o] : owner[o];
            out_valid[o] = locked_xfer[o] || fast_xfer[o];
            out_lock[o]  = (state[o] == LOCKED);
            out_sel[o*SELW +: SELW] = sel_now[o];
            if (out_valid[o]) begin
                pop[sel_now[o]] = 1'b1;
            end
        end
    end

    // Per-output IDLE/LOCKED state, owner and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                state[o] <= IDLE;
                owner[o] <= '0;
                ptr[o]   <= port_idx_t'(NPORT - 1);
            end
        end else begin
            for (int unsigned o = 0; o < NPORT; o++) begin
                case (state[o])
                    IDLE: begin
                        if (arb_any[o]) begin
                            owner[o] <= arb_idx[o];
`ifdef SA_FASTGRANT_EN
                            // A same-cycle single-flit packet releases at once.
                            if (out_ready[o] && in_tail[arb_idx[o]]) begin
                                ptr[o] <= arb_idx[o];
                            end else begin
                                state[o] <= LOCKED;
                            end
`else
                            state[o] <= LOCKED;
`endif
                        end
                    end
                    LOCKED: begin
                        if (locked_xfer[o] && in_tail[owner[o]]) begin
                            state[o] <= IDLE;
                            ptr[o]   <= owner[o];
                        end
                    end
                    default: state[o] <= IDLE;
                endcase
            end
        end
    end

    // Sticky illegal-direction flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_err_q <= 1'b0;
        end else if (dir_bad) begin
            dir_err_q <= 1'b1;
        end
    end

    assign dir_err = dir_err_q;

endmodule
